sha256_wt_calc: RTL and testbench

//  SHA-256 message-schedule word engine: W[t] = W[t-16] + s0(W[t-15]) + W[t-7] + s1(W[t-2]) mod 2^32.

---
 rtl/sha256_wt_calc.sv | 104 ++++++++++
 tb/tb_sha256_wt_calc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sha256_wt_calc.sv
// rtl/sha256_wt_calc.sv - SHA-256 message schedule word engine
// One W[t] per four clocks through a single shared 32-bit adder; sigma functions also exported.
module sha256_wt_calc (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] w_t16,
  input  logic [31:0] w_t15,
  input  logic [31:0] w_t7,
  input  logic [31:0] w_t2,
  output logic [31:0] wt,
  output logic        done,
  output logic        busy,
  input  logic [31:0] sig_in,
  output logic [31:0] sig0_out,
  output logic [31:0] sig1_out
);

  typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] w16_q;
  logic [31:0] w15_q;
  logic [31:0] w7_q;
  logic [31:0] w2_q;
  logic [31:0] acc;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] sum;
  logic        accept;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign sig0_out = sigma0(sig_in);
  assign sig1_out = sigma1(sig_in);

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = S0;
      S0:      state_nx = S1;
      S1:      state_nx = S2;
      S2:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand steering for the single adder; carry-out is simply dropped.
  always_comb begin
    add_a = acc;
    add_b = w7_q;
    case (state)
      S0:      begin add_a = w16_q; add_b = sigma0(w15_q); end
      S2:      add_b = sigma1(w2_q);
      default: ;
    endcase
  end

  assign sum = add_a + add_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w16_q <= '0;
      w15_q <= '0;
      w7_q  <= '0;
      w2_q  <= '0;
      acc   <= '0;
      wt    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        w16_q <= w_t16;
        w15_q <= w_t15;
        w7_q  <= w_t7;
        w2_q  <= w_t2;
      end
      case (state)
        S0, S1: acc <= sum;
        S2: begin
          wt   <= sum;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_wt_calc.sv
// tb/tb_sha256_wt_calc.sv - scoreboard bench for sha256_wt_calc
module tb_sha256_wt_calc;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] w_t16, w_t15, w_t7, w_t2;
  logic [31:0] wt;
  logic        done, busy;
  logic [31:0] sig_in, sig0_out, sig1_out;

  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  sha256_wt_calc dut (
    .clk(clk), .reset(reset), .start(start),
    .w_t16(w_t16), .w_t15(w_t15), .w_t7(w_t7), .w_t2(w_t2),
    .wt(wt), .done(done), .busy(busy),
    .sig_in(sig_in), .sig0_out(sig0_out), .sig1_out(sig1_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] m_wt(input logic [31:0] a, b, c, d);
    return a + m_s0(b) + c + m_s1(d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("wt_result", wt, exp_q.pop_front());
    end
  end

  task automatic launch(input logic [31:0] a, b, c, d);
    w_t16 = a; w_t15 = b; w_t7 = c; w_t2 = d;
    start = 1'b1;
    exp_q.push_back(m_wt(a, b, c, d));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  int dc0;

  initial begin
    reset = 1'b1; start = 1'b0;
    w_t16 = '0; w_t15 = '0; w_t7 = '0; w_t2 = '0; sig_in = '0;
    repeat (2) @(negedge clk);
    check("rst_wt", wt, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);

    sig_in = 32'h00000001; #1;
    check("sig0_1_in_reset", sig0_out, 32'h02004000);
    check("sig1_1_in_reset", sig1_out, 32'h0000A000);
    @(negedge clk);
    reset = 1'b0;
    sig_in = 32'h80000000; #1;
    check("sig0_msb", sig0_out, 32'h11002000);
    check("sig1_msb", sig1_out, 32'h00205000);
    for (int i = 0; i < 4; i++) begin
      sig_in = $urandom; #1;
      check("sig0_rand", sig0_out, m_s0(sig_in));
      check("sig1_rand", sig1_out, m_s1(sig_in));
    end
    @(negedge clk);

    // "abc" W[16]
    launch(32'h61626380, 32'h0, 32'h0, 32'h0);
    check("busy_after_start", {31'b0, busy}, 32'h1);
    check("no_early_done", {31'b0, done}, 32'h0);
    wait_done(lat);
    check("latency_w16", lat, 3);
    check("busy_at_done", {31'b0, busy}, 32'h0);
    check("abc_w16_const", wt, 32'h61626380);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'h0);
    check("wt_held", wt, 32'h61626380);

    // "abc" W[17]
    launch(32'h0, 32'h0, 32'h0, 32'h00000018);
    wait_done(lat);
    check("latency_w17", lat, 3);
    check("abc_w17_const", wt, 32'h000F0000);
    @(negedge clk);

    // wrap mod 2^32
    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat);
    check("latency_ovf", lat, 3);
    check("overflow_const", wt, 32'h203FFFFC);
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      launch($urandom, $urandom, $urandom, $urandom);
      wait_done(lat);
      check("latency_rand", lat, 3);
      @(negedge clk);
    end

    // start held high while busy; inputs scrambled after latch; k+4 accepted
    dc0 = done_cnt;
    launch(32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 32'hF0F0F0F0);
    start = 1'b1;
    w_t16 = 32'hDEADBEEF; w_t15 = 32'hCAFEBABE; w_t7 = 32'h12345678; w_t2 = 32'h87654321;
    @(negedge clk);
    @(negedge clk);
    check("busy_ignore_no_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    check("busy_ignore_done", {31'b0, done}, 32'h1);
    w_t16 = 32'h00000005; w_t15 = 32'h00000006; w_t7 = 32'h00000007; w_t2 = 32'h00000008;
    exp_q.push_back(m_wt(w_t16, w_t15, w_t7, w_t2));
    @(negedge clk);
    start = 1'b0;
    check("k4_accepted", {31'b0, busy}, 32'h1);
    wait_done(lat);
    check("latency_k4", lat, 3);
    repeat (4) @(negedge clk);
    check("busy_seq_pulses", done_cnt - dc0, 2);

    // reset during S1 aborts
    dc0 = done_cnt;
    launch(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    @(negedge clk);
    reset = 1'b1; #1;
    void'(exp_q.pop_back());
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_wt", wt, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_pulse", done_cnt - dc0, 0);
    launch(32'h00000100, 32'h00000200, 32'h00000300, 32'h00000400);
    wait_done(lat);
    check("after_abort_latency", lat, 3);
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
